roce_tx_header_producer: RTL and testbench
==========================================

// Module: roce_tx_header_producer
// PURPOSE
// Consumes framed payload packets plus the matching work request from the PMTU packet framer and emits one
//   RoCEv2 header descriptor per packet (opcode, PSN, QP, RETH, ImmDt, payload length).
// The payload is passed through unchanged, gated behind its header. Sits between the framer and the BTH/RETH header inserter.
// PARAMETERS
// DATA_WIDTH     64   payload bus width in bits; must be a multiple of 8
// PSN_WIDTH      24   PSN width; PSN wraps modulo 2^PSN_WIDTH
// PORTS
// clk                      in   1            clock
// rst                      in   1            asynchronous active-high reset
// s_wr_req_valid/ready     in/out 1          work-request handshake
// s_wr_req_loc_qp          in   24           local QP
// s_wr_req_dma_length      in   32           total transfer bytes
// s_wr_req_addr_offset     in   64           remote virtual address
// s_wr_req_is_immediate    in   1            append ImmDt to the final packet
// s_wr_req_immediate_data  in   32           immediate value
// s_wr_req_tx_type         in   1            0=SEND, 1=RDMA WRITE
// s_axis_tdata/tkeep       in   DATA_WIDTH, DATA_WIDTH/8   framed payload
// s_axis_tvalid/tready/tlast  in/out/in 1    tlast marks end of one PMTU packet
// s_axis_tuser             in   15           [0] bad frame, [1] last packet of transfer, [14:2] packet bytes
// m_hdr_valid/ready        out/in 1          header descriptor handshake
// m_hdr_opcode             out  8            BTH opcode
// m_hdr_psn                out  PSN_WIDTH    BTH PSN
// m_hdr_loc_qp             out  24           QP of the transfer
// m_hdr_reth_valid         out  1            RETH present
// m_hdr_reth_vaddr/len     out  64/32        RETH vaddr and DMA length
// m_hdr_immdt_valid        out  1            ImmDt present
// m_hdr_immdt              out  32           immediate data
// m_hdr_payload_len        out  13           packet payload bytes (from tuser[14:2])
// m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out   payload pass-through
// m_axis_tuser             out  1            bad frame, valid on tlast beat
// cfg_psn_start            in   PSN_WIDTH    starting PSN
// cfg_psn_load             in   1            load cfg_psn_start into the PSN counter
// status_len_mismatch      out  1            one-cycle pulse: summed packet bytes != dma_length
// BEHAVIOUR
// Reset (async): state=IDLE, psn=0, all valid/ready outputs 0, header/status registers 0.
// FSM IDLE: s_wr_req_ready=1. On handshake, latch the request, set first=1, clear byte_sum, go to HDR.
//   cfg_psn_load is honoured only in IDLE; it is ignored in every other state.
//   If a load and a request handshake occur in the same cycle, the load applies first.
// FSM HDR: when s_axis_tvalid=1 (first beat visible, not consumed), register the descriptor and set m_hdr_valid the next cycle.
//   The descriptor holds while valid until m_hdr_ready. On that handshake: psn<=psn+1 (wrap), first<=0, go to PAY.
// Opcode selection, from first and L=s_axis_tuser[1]:
//   first&L      -> ONLY (ONLY_IMM if is_immediate)
//   first&!L     -> FIRST
//   !first&!L    -> MIDDLE
//   !first&L     -> LAST (LAST_IMM if is_immediate)
//   SEND base codes: 0x00..0x05. WRITE base codes: 0x06..0x0B.
// RETH: valid only when tx_type=WRITE and first=1.
// ImmDt: valid only when is_immediate=1 and L=1.
// L and length are sampled from tuser on the first beat of each packet only.
// FSM PAY: s_axis_tready = m_axis_tready; tdata/tkeep/tlast pass through combinationally; m_axis_tuser=s_axis_tuser[0].
//   Outside PAY, s_axis_tready=0 and m_axis_tvalid=0.
//   On the tlast handshake: byte_sum += pkt_len. If L=1, go IDLE; otherwise go HDR.
// Length check: on the final tlast, status_len_mismatch pulses for 1 cycle if byte_sum_next != dma_length.
//   byte_sum is 32 bit and saturates at all-ones.
// Bad frame (tuser[0]) is forwarded only; headers and PSN still advance.
// Back-pressure on m_hdr or m_axis never drops data. Max throughput: 1 header per packet + 1 beat/cycle payload.
// Reset mid-packet aborts immediately: both outputs deassert, PSN returns to 0.
// STRUCTURE
// roce_tx_pkg: opcode localparams (SEND_*/RDMA_WRITE_*), TX_TYPE_SEND=0/TX_TYPE_WRITE=1, and function roce_opcode_sel(tx_type, first, last, imm).
// No sub-module: a single FSM plus header registers and the PSN and byte_sum counters.
// TESTING
// T1: WRITE, 256 B, pmtu 256, psn_start=0x10 -> one header ONLY 0x0A, PSN 0x10, RETH valid, len 256; 32 beats passed through.
// T2: SEND imm=0xDEADBEEF, 1000 B in 3 pkts (256/256/488) -> opcodes 0x00, 0x01, 0x03; PSNs n, n+1, n+2; ImmDt only on the 3rd.
// T3: psn_start=0xFFFFFE, WRITE of 3 pkts -> PSNs 0xFFFFFE, 0xFFFFFF, 0x000000; opcodes 0x06, 0x07, 0x08.
// T4: random m_hdr_ready/m_axis_tready stalls over 100 transfers -> payload bytes and order identical; no header lost or duplicated.
// T5: dma_length=512 with 500 B of packets -> status_len_mismatch pulses once at the final tlast; bad-frame bit forwarded on tlast.
// T6: rst asserted mid-PAY -> outputs low the same cycle; the next transfer starts at PSN 0 with a FIRST/ONLY opcode.

Source files
------------

// File: rtl/roce_tx_pkg.sv
// Shared constants for the RoCEv2 transmit path: BTH opcodes, transfer types,
// field widths and the opcode selection rule.
package roce_tx_pkg;

  localparam int QP_WIDTH      = 24;
  localparam int LEN_WIDTH     = 32;
  localparam int ADDR_WIDTH    = 64;
  localparam int IMM_WIDTH     = 32;
  localparam int PKT_LEN_WIDTH = 13;
  localparam int S_USER_WIDTH  = 15;

  localparam logic TX_TYPE_SEND  = 1'b0;
  localparam logic TX_TYPE_WRITE = 1'b1;

  localparam logic [7:0] SEND_FIRST           = 8'h00;
  localparam logic [7:0] SEND_MIDDLE          = 8'h01;
  localparam logic [7:0] SEND_LAST            = 8'h02;
  localparam logic [7:0] SEND_LAST_IMM        = 8'h03;
  localparam logic [7:0] SEND_ONLY            = 8'h04;
  localparam logic [7:0] SEND_ONLY_IMM        = 8'h05;
  localparam logic [7:0] RDMA_WRITE_FIRST     = 8'h06;
  localparam logic [7:0] RDMA_WRITE_MIDDLE    = 8'h07;
  localparam logic [7:0] RDMA_WRITE_LAST      = 8'h08;
  localparam logic [7:0] RDMA_WRITE_LAST_IMM  = 8'h09;
  localparam logic [7:0] RDMA_WRITE_ONLY      = 8'h0A;
  localparam logic [7:0] RDMA_WRITE_ONLY_IMM  = 8'h0B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY
  } state_t;

  function automatic logic [7:0] roce_opcode_sel(input logic tx_type, input logic first,
                                                 input logic last, input logic imm);
    logic wr;
    wr = (tx_type == TX_TYPE_WRITE);
    unique case ({first, last})
      2'b11:   return imm ? (wr ? RDMA_WRITE_ONLY_IMM : SEND_ONLY_IMM)
                          : (wr ? RDMA_WRITE_ONLY     : SEND_ONLY);
      2'b10:   return wr ? RDMA_WRITE_FIRST : SEND_FIRST;
      2'b00:   return wr ? RDMA_WRITE_MIDDLE : SEND_MIDDLE;
      default: return imm ? (wr ? RDMA_WRITE_LAST_IMM : SEND_LAST_IMM)
                          : (wr ? RDMA_WRITE_LAST     : SEND_LAST);
    endcase
  endfunction

endpackage

// File: rtl/roce_tx_header_producer_if.sv
// Bus interfaces around the header producer: work request, AXI-Stream payload
// and the header descriptor handed to the BTH/RETH inserter.
interface wr_req_if
  import roce_tx_pkg::*;
  ;
  logic                  valid;
  logic                  ready;
  logic [QP_WIDTH-1:0]   loc_qp;
  logic [LEN_WIDTH-1:0]  dma_length;
  logic [ADDR_WIDTH-1:0] addr_offset;
  logic                  is_immediate;
  logic [IMM_WIDTH-1:0]  immediate_data;
  logic                  tx_type;

  modport master (output valid, loc_qp, dma_length, addr_offset, is_immediate,
                         immediate_data, tx_type,
                  input  ready);
  modport slave  (input  valid, loc_qp, dma_length, addr_offset, is_immediate,
                         immediate_data, tx_type,
                  output ready);
endinterface

interface axis_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input  tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

interface hdr_if
  import roce_tx_pkg::*;
  #(parameter int PSN_WIDTH = 24);
  logic                     valid;
  logic                     ready;
  logic [7:0]               opcode;
  logic [PSN_WIDTH-1:0]     psn;
  logic [QP_WIDTH-1:0]      loc_qp;
  logic                     reth_valid;
  logic [ADDR_WIDTH-1:0]    reth_vaddr;
  logic [LEN_WIDTH-1:0]     reth_len;
  logic                     immdt_valid;
  logic [IMM_WIDTH-1:0]     immdt;
  logic [PKT_LEN_WIDTH-1:0] payload_len;

  modport master (output valid, opcode, psn, loc_qp, reth_valid, reth_vaddr, reth_len,
                         immdt_valid, immdt, payload_len,
                  input  ready);
  modport slave  (input  valid, opcode, psn, loc_qp, reth_valid, reth_vaddr, reth_len,
                         immdt_valid, immdt, payload_len,
                  output ready);
endinterface

// File: rtl/roce_tx_header_producer.sv
// Emits one RoCEv2 header descriptor per framed packet of a work request and
// passes the payload through once that header has been accepted.
module roce_tx_header_producer
  import roce_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int PSN_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  wr_req_if.slave              s_wr_req,
  axis_if.slave                s_axis,
  hdr_if.master                m_hdr,
  axis_if.master               m_axis,
  input  logic [PSN_WIDTH-1:0] cfg_psn_start,
  input  logic                 cfg_psn_load,
  output logic                 status_len_mismatch
);

  state_t                state;
  logic [PSN_WIDTH-1:0]  psn;
  logic                  first;
  logic                  last_pkt;
  logic [LEN_WIDTH-1:0]  byte_sum;
  logic [QP_WIDTH-1:0]   req_qp;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_imm;
  logic [IMM_WIDTH-1:0]  req_imm_data;
  logic                  req_tx_type;

  logic                  pay;
  logic                  pkt_l;
  logic                  last_beat_hs;
  logic [LEN_WIDTH:0]    sum_wide;
  logic [LEN_WIDTH-1:0]  byte_sum_next;

  // Payload is gated behind its header: beats move only in PAY, one per cycle.
  assign pay           = (state == ST_PAY);
  assign s_axis.tready = pay & m_axis.tready;
  assign m_axis.tvalid = pay & s_axis.tvalid;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser[0];

  assign pkt_l         = s_axis.tuser[1];
  assign last_beat_hs  = pay & s_axis.tvalid & m_axis.tready & s_axis.tlast;
  assign sum_wide      = {1'b0, byte_sum} + (LEN_WIDTH+1)'(m_hdr.payload_len);
  assign byte_sum_next = sum_wide[LEN_WIDTH] ? '1 : sum_wide[LEN_WIDTH-1:0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      psn                 <= '0;
      first               <= 1'b0;
      last_pkt            <= 1'b0;
      byte_sum            <= '0;
      req_qp              <= '0;
      req_len             <= '0;
      req_addr            <= '0;
      req_imm             <= 1'b0;
      req_imm_data        <= '0;
      req_tx_type         <= 1'b0;
      s_wr_req.ready      <= 1'b0;
      m_hdr.valid         <= 1'b0;
      m_hdr.opcode        <= '0;
      m_hdr.psn           <= '0;
      m_hdr.loc_qp        <= '0;
      m_hdr.reth_valid    <= 1'b0;
      m_hdr.reth_vaddr    <= '0;
      m_hdr.reth_len      <= '0;
      m_hdr.immdt_valid   <= 1'b0;
      m_hdr.immdt         <= '0;
      m_hdr.payload_len   <= '0;
      status_len_mismatch <= 1'b0;
    end else begin
      status_len_mismatch <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          s_wr_req.ready <= 1'b1;
          if (cfg_psn_load) psn <= cfg_psn_start;
          if (s_wr_req.valid && s_wr_req.ready) begin
            req_qp         <= s_wr_req.loc_qp;
            req_len        <= s_wr_req.dma_length;
            req_addr       <= s_wr_req.addr_offset;
            req_imm        <= s_wr_req.is_immediate;
            req_imm_data   <= s_wr_req.immediate_data;
            req_tx_type    <= s_wr_req.tx_type;
            first          <= 1'b1;
            byte_sum       <= '0;
            s_wr_req.ready <= 1'b0;
            state          <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!m_hdr.valid) begin
            // The first beat is only inspected here; it is consumed in PAY.
            if (s_axis.tvalid) begin
              m_hdr.valid       <= 1'b1;
              m_hdr.opcode      <= roce_opcode_sel(req_tx_type, first, pkt_l, req_imm);
              m_hdr.psn         <= psn;
              m_hdr.loc_qp      <= req_qp;
              m_hdr.reth_valid  <= (req_tx_type == TX_TYPE_WRITE) && first;
              m_hdr.reth_vaddr  <= req_addr;
              m_hdr.reth_len    <= req_len;
              m_hdr.immdt_valid <= req_imm && pkt_l;
              m_hdr.immdt       <= req_imm_data;
              m_hdr.payload_len <= s_axis.tuser[S_USER_WIDTH-1:2];
              last_pkt          <= pkt_l;
            end
          end else if (m_hdr.ready) begin
            m_hdr.valid <= 1'b0;
            psn         <= psn + 1'b1;
            first       <= 1'b0;
            state       <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (last_beat_hs) begin
            byte_sum <= byte_sum_next;
            if (last_pkt) begin
              status_len_mismatch <= (byte_sum_next != req_len);
              s_wr_req.ready      <= 1'b1;
              state               <= ST_IDLE;
            end else begin
              state <= ST_HDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roce_tx_header_producer.sv
// Self-checking bench: directed transfer table, a mid-packet reset sequence and
// randomized transfers with stalls, all compared against a transfer-level model.
module tb_roce_tx_header_producer;

  localparam int TIMEOUT = 2000;

  typedef struct packed {
    logic             tx_type;
    logic             imm;
    logic [31:0]      imm_data;
    logic [23:0]      qp;
    logic [63:0]      vaddr;
    logic             load;
    logic [23:0]      psn_start;
    logic [2:0]       npkt;
    logic [3:0][12:0] len;
    logic [31:0]      dma_len;
    logic [3:0]       bad;
    logic [3:0][7:0]  exp_op;
    logic [3:0][23:0] exp_psn;
    logic             exp_mismatch;
  } vec_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [23:0] qp;
    logic        reth_v;
    logic [63:0] vaddr;
    logic [31:0] rlen;
    logic        imm_v;
    logic [31:0] imm;
    logic [12:0] plen;
  } hdr_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cfg_psn_start = '0;
  logic        cfg_psn_load = 1'b0;
  logic        status_len_mismatch;

  wr_req_if                                   s_wr_req ();
  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(15)) s_axis ();
  hdr_if  #(.PSN_WIDTH(24))                   m_hdr ();
  axis_if #(.DATA_WIDTH(64), .USER_WIDTH(1))  m_axis ();

  roce_tx_header_producer #(.DATA_WIDTH(64), .PSN_WIDTH(24)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_wr_req            (s_wr_req),
    .s_axis              (s_axis),
    .m_hdr               (m_hdr),
    .m_axis              (m_axis),
    .cfg_psn_start       (cfg_psn_start),
    .cfg_psn_load        (cfg_psn_load),
    .status_len_mismatch (status_len_mismatch)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  bit    aborted = 1'b0;
  bit    stall_en = 1'b0;
  int    mism_cnt = 0;
  hdr_t  got_hdr[$];
  beat_t got_beat[$];
  logic [23:0] psn_model = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  // Downstream ready generator: always ready, or randomly stalling.
  initial begin
    m_hdr.ready   = 1'b1;
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_hdr.ready   = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis.tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Handshakes are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    hdr_t  h;
    beat_t b;
    if (m_hdr.valid && m_hdr.ready) begin
      h.op = m_hdr.opcode;         h.psn = m_hdr.psn;          h.qp = m_hdr.loc_qp;
      h.reth_v = m_hdr.reth_valid; h.vaddr = m_hdr.reth_vaddr; h.rlen = m_hdr.reth_len;
      h.imm_v = m_hdr.immdt_valid; h.imm = m_hdr.immdt;        h.plen = m_hdr.payload_len;
      got_hdr.push_back(h);
    end
    if (m_axis.tvalid && m_axis.tready) begin
      b.data = m_axis.tdata; b.keep = m_axis.tkeep; b.last = m_axis.tlast; b.user = m_axis.tuser[0];
      got_beat.push_back(b);
    end
    if (status_len_mismatch) mism_cnt++;
  end

  task automatic wait_sig(input bit sel_tready, input string name);
    int cnt = 0;
    if (aborted) return;
    forever begin
      @(negedge clk);
      if (sel_tready ? s_axis.tready : s_wr_req.ready) return;
      cnt++;
      if (cnt > TIMEOUT) begin
        check(name, 64'(sel_tready ? s_axis.tready : s_wr_req.ready), 64'd1);
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive_req(input vec_t v);
    @(posedge clk);
    #1;
    s_wr_req.valid          = 1'b1;
    s_wr_req.loc_qp         = v.qp;
    s_wr_req.dma_length     = v.dma_len;
    s_wr_req.addr_offset    = v.vaddr;
    s_wr_req.is_immediate   = v.imm;
    s_wr_req.immediate_data = v.imm_data;
    s_wr_req.tx_type        = v.tx_type;
    cfg_psn_load            = v.load;
    cfg_psn_start           = v.psn_start;
    wait_sig(1'b0, "req_ready_timeout");
    @(posedge clk);
    #1;
    s_wr_req.valid = 1'b0;
    cfg_psn_load   = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b, input logic [14:0] user);
    if (aborted) return;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = b.data;
    s_axis.tkeep  = b.keep;
    s_axis.tlast  = b.last;
    s_axis.tuser  = user;
    wait_sig(1'b1, "tready_timeout");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] keep_for(input int len);
    int rem = len % 8;
    return (rem == 0) ? 8'hFF : 8'(8'hFF >> (8 - rem));
  endfunction

  // Opcode from packet position within the transfer.
  function automatic logic [7:0] model_opcode(input vec_t v, input int i);
    int base = v.tx_type ? 6 : 0;
    int n    = int'(v.npkt);
    if (n == 1)          return 8'(base + (v.imm ? 5 : 4));
    else if (i == 0)     return 8'(base);
    else if (i == n - 1) return 8'(base + (v.imm ? 3 : 2));
    else                 return 8'(base + 1);
  endfunction

  task automatic run_transfer(input vec_t v, input bit use_table, input string tag);
    hdr_t        eh[$];
    beat_t       eb[$];
    logic [14:0] users[$];
    int          sum = 0;
    int          n = int'(v.npkt);
    hdr_t        h;
    beat_t       b;
    if (aborted) return;
    if (v.load) psn_model = v.psn_start;
    for (int i = 0; i < n; i++) begin
      int nb = (int'(v.len[i]) + 7) / 8;
      h.op     = use_table ? v.exp_op[i] : model_opcode(v, i);
      h.psn    = use_table ? v.exp_psn[i] : psn_model;
      h.qp     = v.qp;
      h.reth_v = v.tx_type && (i == 0);
      h.vaddr  = v.vaddr;
      h.rlen   = v.dma_len;
      h.imm_v  = v.imm && (i == n - 1);
      h.imm    = v.imm_data;
      h.plen   = v.len[i];
      eh.push_back(h);
      psn_model = psn_model + 24'd1;
      sum += int'(v.len[i]);
      for (int k = 0; k < nb; k++) begin
        b.data = {$urandom, $urandom};
        b.keep = (k == nb - 1) ? keep_for(int'(v.len[i])) : 8'hFF;
        b.last = (k == nb - 1);
        b.user = v.bad[i];
        eb.push_back(b);
        users.push_back({v.len[i], 1'(i == n - 1), v.bad[i]});
      end
    end
    got_hdr.delete();
    got_beat.delete();
    mism_cnt = 0;
    drive_req(v);
    for (int k = 0; k < eb.size(); k++) drive_beat(eb[k], users[k]);
    s_axis.tvalid = 1'b0;
    repeat (3) @(negedge clk);

    check({tag, "_hdr_count"}, 64'(got_hdr.size()), 64'(eh.size()));
    for (int i = 0; i < eh.size() && i < got_hdr.size(); i++) begin
      check({tag, "_opcode"}, 64'(got_hdr[i].op), 64'(eh[i].op));
      check({tag, "_psn"}, 64'(got_hdr[i].psn), 64'(eh[i].psn));
      check({tag, "_qp"}, 64'(got_hdr[i].qp), 64'(eh[i].qp));
      check({tag, "_reth_valid"}, 64'(got_hdr[i].reth_v), 64'(eh[i].reth_v));
      if (eh[i].reth_v) begin
        check({tag, "_reth_vaddr"}, got_hdr[i].vaddr, eh[i].vaddr);
        check({tag, "_reth_len"}, 64'(got_hdr[i].rlen), 64'(eh[i].rlen));
      end
      check({tag, "_immdt_valid"}, 64'(got_hdr[i].imm_v), 64'(eh[i].imm_v));
      if (eh[i].imm_v) check({tag, "_immdt"}, 64'(got_hdr[i].imm), 64'(eh[i].imm));
      check({tag, "_payload_len"}, 64'(got_hdr[i].plen), 64'(eh[i].plen));
    end
    check({tag, "_beat_count"}, 64'(got_beat.size()), 64'(eb.size()));
    for (int k = 0; k < eb.size() && k < got_beat.size(); k++) begin
      check({tag, "_tdata"}, got_beat[k].data, eb[k].data);
      check({tag, "_keep_last_user"}, 64'({got_beat[k].keep, got_beat[k].last, got_beat[k].user}),
            64'({eb[k].keep, eb[k].last, eb[k].user}));
    end
    check({tag, "_len_mismatch_pulses"}, 64'(mism_cnt),
          64'(use_table ? v.exp_mismatch : (sum != int'(v.dma_len))));
  endtask

  function automatic vec_t mk(input logic tx_type, input logic imm, input logic [31:0] imm_data,
                              input logic load, input logic [23:0] psn_start, input int npkt,
                              input logic [3:0][12:0] len, input logic [31:0] dma_len,
                              input logic [3:0] bad, input logic [3:0][7:0] op,
                              input logic [3:0][23:0] psn, input logic mism);
    vec_t v;
    v.tx_type = tx_type; v.imm = imm; v.imm_data = imm_data;
    v.qp = 24'h00_0123; v.vaddr = 64'h0000_7F00_1234_5000;
    v.load = load; v.psn_start = psn_start; v.npkt = 3'(npkt); v.len = len;
    v.dma_len = dma_len; v.bad = bad; v.exp_op = op; v.exp_psn = psn; v.exp_mismatch = mism;
    return v;
  endfunction

  initial begin
    vec_t tbl[5];
    vec_t v;
    beat_t b;
    int sum;

    s_wr_req.valid = 1'b0;  s_wr_req.loc_qp = '0;       s_wr_req.dma_length = '0;
    s_wr_req.addr_offset = '0; s_wr_req.is_immediate = 1'b0; s_wr_req.immediate_data = '0;
    s_wr_req.tx_type = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0; s_axis.tuser = '0;

    // Index order in packed arrays is [3]..[0], so the first packet is rightmost.
    tbl[0] = mk(1, 0, 32'h0, 1, 24'h000010, 1, {13'd0, 13'd0, 13'd0, 13'd256}, 32'd256, 4'b0000,
                {8'h0, 8'h0, 8'h0, 8'h0A}, {24'h0, 24'h0, 24'h0, 24'h000010}, 1'b0);
    tbl[1] = mk(0, 1, 32'hDEADBEEF, 1, 24'h000100, 3, {13'd0, 13'd488, 13'd256, 13'd256}, 32'd1000,
                4'b0000, {8'h0, 8'h03, 8'h01, 8'h00}, {24'h0, 24'h000102, 24'h000101, 24'h000100}, 1'b0);
    tbl[2] = mk(1, 0, 32'h0, 1, 24'hFFFFFE, 3, {13'd0, 13'd100, 13'd256, 13'd256}, 32'd612, 4'b0000,
                {8'h0, 8'h08, 8'h07, 8'h06}, {24'h0, 24'h000000, 24'hFFFFFF, 24'hFFFFFE}, 1'b0);
    tbl[3] = mk(0, 0, 32'h0, 0, 24'h0, 2, {13'd0, 13'd0, 13'd244, 13'd256}, 32'd512, 4'b0010,
                {8'h0, 8'h0, 8'h02, 8'h00}, {24'h0, 24'h0, 24'h000002, 24'h000001}, 1'b1);
    tbl[4] = mk(1, 1, 32'hCAFE0001, 1, 24'h000005, 1, {13'd0, 13'd0, 13'd0, 13'd61}, 32'd61, 4'b0001,
                {8'h0, 8'h0, 8'h0, 8'h0B}, {24'h0, 24'h0, 24'h0, 24'h000005}, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(s_wr_req.ready), 64'd0);
    check("reset_hdr_valid", 64'(m_hdr.valid), 64'd0);
    check("reset_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("reset_s_tready", 64'(s_axis.tready), 64'd0);
    check("reset_mismatch", 64'(status_len_mismatch), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_req_ready", 64'(s_wr_req.ready), 64'd1);

    for (int i = 0; i < 5; i++) run_transfer(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Reset in the middle of a packet's payload.
    v = mk(1, 0, 32'h0, 1, 24'h000055, 2, {13'd0, 13'd0, 13'd256, 13'd256}, 32'd512, 4'b0000,
           '0, '0, 1'b0);
    drive_req(v);
    for (int k = 0; k < 4; k++) begin
      b.data = {$urandom, $urandom}; b.keep = 8'hFF; b.last = 1'b0; b.user = 1'b0;
      drive_beat(b, {13'd256, 1'b0, 1'b0});
    end
    check("pre_reset_in_pay", 64'(m_axis.tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_axis.tready), 64'd0);
    check("rst_hdr_valid", 64'(m_hdr.valid), 64'd0);
    check("rst_req_ready", 64'(s_wr_req.ready), 64'd0);
    s_axis.tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    psn_model = '0;
    v = mk(1, 0, 32'h0, 0, 24'h0, 1, {13'd0, 13'd0, 13'd0, 13'd128}, 32'd128, 4'b0000,
           {8'h0, 8'h0, 8'h0, 8'h0A}, {24'h0, 24'h0, 24'h0, 24'h000000}, 1'b0);
    run_transfer(v, 1'b1, "post_rst_only");
    v = mk(0, 0, 32'h0, 0, 24'h0, 2, {13'd0, 13'd0, 13'd8, 13'd256}, 32'd264, 4'b0000,
           {8'h0, 8'h0, 8'h02, 8'h00}, {24'h0, 24'h0, 24'h000002, 24'h000001}, 1'b0);
    run_transfer(v, 1'b1, "post_rst_send");

    stall_en = 1'b1;
    for (int t = 0; t < 100 && !aborted; t++) begin
      v.tx_type  = 1'($urandom_range(0, 1));
      v.imm      = 1'($urandom_range(0, 1));
      v.imm_data = $urandom;
      v.qp       = 24'($urandom);
      v.vaddr    = {$urandom, $urandom};
      v.load     = ($urandom_range(0, 3) == 0);
      v.psn_start = ($urandom_range(0, 1) == 1) ? 24'(24'hFFFFFF - $urandom_range(0, 3)) : 24'($urandom);
      v.npkt     = 3'($urandom_range(1, 4));
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        v.len[i] = (i == int'(v.npkt) - 1) ? 13'($urandom_range(1, 256)) : 13'd256;
        v.bad[i] = ($urandom_range(0, 7) == 0);
        if (i < int'(v.npkt)) sum += int'(v.len[i]);
      end
      v.dma_len = ($urandom_range(0, 7) == 0) ? 32'(sum + $urandom_range(1, 50)) : 32'(sum);
      v.exp_op = '0; v.exp_psn = '0; v.exp_mismatch = 1'b0;
      run_transfer(v, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
